// File: rtl/otter_wb_arbiter.sv
// Purpose: round-robin writeback arbiter feeding the RegisterFile write port from ALU and load FIFOs.
// Latency: a result accepted at edge N appears on EN/WA/WD after edge N+1 when uncontended.
// Backpressure: each source sees READY=0 while its FIFO holds DEPTH entries; a same-cycle pop does not help.
//
// Ports:
//   CLK, RST                          clock, asynchronous active-high reset
//   ALU_VALID/ALU_RD/ALU_DATA/ALU_READY  ALU result handshake
//   MEM_VALID/MEM_RD/MEM_DATA/MEM_READY  load result handshake
//   WA, WD, EN                        registered RegisterFile write port
//   PEND_ADR, PEND_HIT                pending-write query for hazard logic

// Generic in-order FIFO with an MSB key view of every slot for associative lookups.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: push_rdy drops when full or in reset; a pop in the same cycle does not raise it.
module otter_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    parameter int KEYW  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    output logic                       push_rdy,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       empty,
    output logic [DEPTH-1:0][KEYW-1:0] ent_key,
    output logic [DEPTH-1:0]           ent_vld
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               count;

    assign push_rdy = (count < CW'(DEPTH)) && !rst;
    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);

    // A slot is live when its distance from the read pointer (mod DEPTH) is below the fill count.
    always_comb begin
        ent_key = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_key[i] = mem[i][WIDTH-1 -: KEYW];
            ent_vld[i] = ({1'b0, (PW'(i) - rd_ptr)} < count);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module otter_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_RD,
    input  logic [31:0] ALU_DATA,
    output logic        ALU_READY,
    input  logic        MEM_VALID,
    input  logic [4:0]  MEM_RD,
    input  logic [31:0] MEM_DATA,
    output logic        MEM_READY,
    output logic [4:0]  WA,
    output logic [31:0] WD,
    output logic        EN,
    input  logic [4:0]  PEND_ADR,
    output logic        PEND_HIT
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    localparam int WBW = $bits(wb_t);

    wb_t                   alu_head;
    wb_t                   mem_head;
    logic [DEPTH-1:0][4:0] alu_key;
    logic [DEPTH-1:0][4:0] mem_key;
    logic [DEPTH-1:0]      alu_key_vld;
    logic [DEPTH-1:0]      mem_key_vld;
    logic                  alu_empty;
    logic                  mem_empty;
    logic                  alu_push;
    logic                  mem_push;
    logic                  grant_alu;
    logic                  grant_mem;
    logic                  prefer_mem;
    logic                  fifo_hit;

    // A handshake with rd=0 completes but is discarded, so x0 is never written.
    assign alu_push = ALU_VALID && ALU_READY && (ALU_RD != 5'd0);
    assign mem_push = MEM_VALID && MEM_READY && (MEM_RD != 5'd0);

    otter_wb_fifo #(.WIDTH(WBW), .DEPTH(DEPTH), .KEYW(5)) u_alu_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (alu_push),
        .push_dat ({ALU_RD, ALU_DATA}),
        .push_rdy (ALU_READY),
        .pop      (grant_alu),
        .head_dat (alu_head),
        .empty    (alu_empty),
        .ent_key  (alu_key),
        .ent_vld  (alu_key_vld)
    );

    otter_wb_fifo #(.WIDTH(WBW), .DEPTH(DEPTH), .KEYW(5)) u_mem_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (mem_push),
        .push_dat ({MEM_RD, MEM_DATA}),
        .push_rdy (MEM_READY),
        .pop      (grant_mem),
        .head_dat (mem_head),
        .empty    (mem_empty),
        .ent_key  (mem_key),
        .ent_vld  (mem_key_vld)
    );

    // prefer_mem remembers who lost the last grant; it only moves when something is granted.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!alu_empty && !mem_empty) begin
            if (prefer_mem) grant_mem = 1'b1;
            else            grant_alu = 1'b1;
        end else if (!alu_empty) begin
            grant_alu = 1'b1;
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EN         <= 1'b0;
            WA         <= 5'd0;
            WD         <= 32'd0;
            prefer_mem <= 1'b0;
        end else begin
            EN <= grant_alu || grant_mem;
            if (grant_alu) begin
                WA         <= alu_head.rd;
                WD         <= alu_head.data;
                prefer_mem <= 1'b1;
            end else if (grant_mem) begin
                WA         <= mem_head.rd;
                WD         <= mem_head.data;
                prefer_mem <= 1'b0;
            end
        end
    end

    // Associative search over every live slot of both FIFOs.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_key_vld[i] && (alu_key[i] == PEND_ADR)) fifo_hit = 1'b1;
            if (mem_key_vld[i] && (mem_key[i] == PEND_ADR)) fifo_hit = 1'b1;
        end
    end

    // The output register counts as pending until the RegisterFile has taken it.
    assign PEND_HIT = !RST && (PEND_ADR != 5'd0) &&
                      (fifo_hit || (EN && (WA == PEND_ADR)));

endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Purpose: self-checking bench for otter_wb_arbiter against a queue-based reference model.
// Latency: model predicts EN/WA/WD one edge after acceptance and checks READY/PEND_HIT combinationally.
// Backpressure: stimulus holds VALID and payload stable until the model says the handshake completed.
module tb_otter_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        CLK;
    logic        RST;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [31:0] ALU_DATA;
    logic        ALU_READY;
    logic        MEM_VALID;
    logic [4:0]  MEM_RD;
    logic [31:0] MEM_DATA;
    logic        MEM_READY;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic        EN;
    logic [4:0]  PEND_ADR;
    logic        PEND_HIT;

    otter_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALU_VALID (ALU_VALID),
        .ALU_RD    (ALU_RD),
        .ALU_DATA  (ALU_DATA),
        .ALU_READY (ALU_READY),
        .MEM_VALID (MEM_VALID),
        .MEM_RD    (MEM_RD),
        .MEM_DATA  (MEM_DATA),
        .MEM_READY (MEM_READY),
        .WA        (WA),
        .WD        (WD),
        .EN        (EN),
        .PEND_ADR  (PEND_ADR),
        .PEND_HIT  (PEND_HIT)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    // Minimal RegisterFile consuming the write port.
    logic [31:0] rf [32];
    always @(posedge CLK) if (EN) rf[WA] <= WD;

    int vectors = 0;
    int errors  = 0;

    // Reference model: per-source queues, who was granted last, and the output register.
    ent_t        aq[$];
    ent_t        mq[$];
    ent_t        wlog[$];
    bit          last_mem;
    logic        m_en;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          acc_a;
    bit          acc_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (aq[i]) if (aq[i].rd == a) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        if (m_en && (m_wa == a)) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check combinational outputs, predict the edge, check registered outputs.
    task automatic cycle();
        bit   a_acc;
        bit   m_acc;
        int   g;
        ent_t a_in;
        ent_t m_in;
        ent_t e;
        #1;
        chk("alu_ready", ALU_READY, aq.size() < DEPTH);
        chk("mem_ready", MEM_READY, mq.size() < DEPTH);
        chk("pend_hit",  PEND_HIT,  model_hit(PEND_ADR));
        a_acc = ALU_VALID && (aq.size() < DEPTH);
        m_acc = MEM_VALID && (mq.size() < DEPTH);
        a_in  = '{ALU_RD, ALU_DATA};
        m_in  = '{MEM_RD, MEM_DATA};
        g = 0;
        if (aq.size() != 0 && mq.size() != 0) g = last_mem ? 1 : 2;
        else if (aq.size() != 0)              g = 1;
        else if (mq.size() != 0)              g = 2;
        @(posedge CLK);
        #1;
        e = '0;
        if (g == 1) begin
            e = aq.pop_front();
            last_mem = 1'b0;
        end else if (g == 2) begin
            e = mq.pop_front();
            last_mem = 1'b1;
        end
        m_en = (g != 0);
        if (g != 0) begin
            m_wa = e.rd;
            m_wd = e.data;
            wlog.push_back(e);
        end
        if (a_acc && a_in.rd != 5'd0) aq.push_back(a_in);
        if (m_acc && m_in.rd != 5'd0) mq.push_back(m_in);
        chk("en", EN, m_en);
        chk("wa", WA, m_wa);
        chk("wd", WD, m_wd);
        acc_a = a_acc;
        acc_m = m_acc;
    endtask

    // Asynchronous reset pulse: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        PEND_ADR = 5'd13;
        RST = 1'b1;
        #1;
        chk("rst_en",        EN,        0);
        chk("rst_wa",        WA,        0);
        chk("rst_wd",        WD,        0);
        chk("rst_alu_ready", ALU_READY, 0);
        chk("rst_mem_ready", MEM_READY, 0);
        chk("rst_pend",      PEND_HIT,  0);
        aq.delete();
        mq.delete();
        last_mem  = 1'b1;
        m_en      = 1'b0;
        m_wa      = 5'd0;
        m_wd      = 32'd0;
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;
        acc_a     = 1'b0;
        acc_m     = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("rel_alu_ready", ALU_READY, 1);
        chk("rel_mem_ready", MEM_READY, 1);
    endtask

    task automatic sweep();
        for (int a = 0; a < 32; a++) begin
            PEND_ADR = a[4:0];
            #1;
            chk("pend_sweep", PEND_HIT, model_hit(PEND_ADR));
        end
    endtask

    logic [4:0] cont_exp [4] = '{5'd2, 5'd4, 5'd3, 5'd5};

    initial begin
        int  next_a;
        int  n_a;
        int  k;
        int  mk;
        bit  saw_full;

        RST = 1'b0; ALU_VALID = 1'b0; ALU_RD = '0; ALU_DATA = '0;
        MEM_VALID = 1'b0; MEM_RD = '0; MEM_DATA = '0; PEND_ADR = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        @(posedge CLK);
        #1;
        do_reset();
        repeat (2) cycle();

        // Single write: accept at edge N, visible after N+1, committed at N+2.
        ALU_VALID = 1'b1; ALU_RD = 5'd1; ALU_DATA = 32'h12;
        cycle();
        ALU_VALID = 1'b0;
        cycle();
        chk("single_en", EN, 1);
        chk("single_wa", WA, 5'd1);
        chk("single_wd", WD, 32'h12);
        cycle();
        chk("single_rf", rf[1], 32'h12);

        // rd=0 is accepted and dropped.
        MEM_VALID = 1'b1; MEM_RD = 5'd0; MEM_DATA = 32'hFF; PEND_ADR = 5'd0;
        cycle();
        MEM_VALID = 1'b0;
        repeat (3) begin
            cycle();
            chk("drop_en",   EN,       0);
            chk("drop_hit0", PEND_HIT, 0);
        end

        // Contention from reset: ALU first, then alternate.
        do_reset();
        wlog.delete();
        ALU_VALID = 1'b1; ALU_RD = 5'd2; ALU_DATA = 32'h2;
        MEM_VALID = 1'b1; MEM_RD = 5'd4; MEM_DATA = 32'h4;
        cycle();
        ALU_RD = 5'd3; ALU_DATA = 32'h3;
        MEM_RD = 5'd5; MEM_DATA = 32'h5;
        cycle();
        ALU_VALID = 1'b0; MEM_VALID = 1'b0;
        repeat (5) cycle();
        chk("cont_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < wlog.size()) chk("cont_wa", wlog[i].rd, cont_exp[i]);
        chk("cont_idle_en", EN, 0);

        // Mid-stream reset with three entries queued.
        ALU_VALID = 1'b1; ALU_RD = 5'd10; ALU_DATA = 32'hA10;
        MEM_VALID = 1'b1; MEM_RD = 5'd11; MEM_DATA = 32'hB11;
        cycle();
        ALU_RD = 5'd12; ALU_DATA = 32'hA12;
        MEM_RD = 5'd13; MEM_DATA = 32'hB13;
        cycle();
        chk("pre_rst_en", EN, 1);
        do_reset();
        repeat (3) begin
            cycle();
            chk("post_rst_en", EN, 0);
        end

        // Backpressure: MEM streams alongside so the ALU FIFO fills up.
        do_reset();
        wlog.delete();
        next_a = 7; n_a = 0; mk = 0; saw_full = 1'b0;
        for (int c = 0; c < 16; c++) begin
            ALU_VALID = 1'b1; ALU_RD = next_a[4:0]; ALU_DATA = 32'hA000_0000 + next_a;
            MEM_VALID = 1'b1; MEM_RD = 5'd24 + 5'(mk % 7); MEM_DATA = 32'hB000_0000 + mk;
            PEND_ADR = 5'($urandom_range(0, 31));
            cycle();
            if (acc_a) begin n_a++; next_a++; end
            if (acc_m) mk++;
            if (!ALU_READY) saw_full = 1'b1;
        end
        ALU_VALID = 1'b0; MEM_VALID = 1'b0;
        repeat (8) cycle();
        chk("bp_full_seen", saw_full, 1);
        k = 0;
        foreach (wlog[i]) begin
            if (wlog[i].data[31:28] == 4'hA) begin
                chk("bp_order", wlog[i].rd, 7 + k);
                k++;
            end
        end
        chk("bp_count", k, n_a);

        // Pending query on rd=31 across its lifetime.
        do_reset();
        ALU_VALID = 1'b1; ALU_RD = 5'd31; ALU_DATA = 32'hDEAD_BEEF;
        for (int p = 0; p < 5; p++) begin
            PEND_ADR = 5'd31;
            #1;
            chk("pend31", PEND_HIT, (p == 1 || p == 2));
            sweep();
            cycle();
            ALU_VALID = 1'b0;
        end

        // Randomized traffic with protocol-correct holding and periodic resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 200 == 199) do_reset();
            if (!ALU_VALID || acc_a) begin
                ALU_VALID = ($urandom_range(0, 9) < 6);
                ALU_RD    = 5'($urandom_range(0, 7));
                ALU_DATA  = $urandom;
            end
            if (!MEM_VALID || acc_m) begin
                MEM_VALID = ($urandom_range(0, 9) < 6);
                MEM_RD    = 5'($urandom_range(0, 7));
                MEM_DATA  = $urandom;
            end
            PEND_ADR = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
